uart_rx_port: RTL and testbench

Serial receiver that deserialises 8N1 asynchronous frames arriving on a single line and presents each byte to the PicoBlaze as an input-port register with ready/overrun/framing status. It sits beside the `timers_top` processor subsystem and is the receive counterpart of the existing TX path: host-to-board commands enter here, and board-to-host traffic leaves on TX. Oversampling is 16x, derived from CLK_IN by an integer divider.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_port_if.sv | 27 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_port.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_port.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
// Holds the line-state encoding, oversampling constants and divisor math.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SUB_W = $clog2(OVERSAMPLE);

    localparam logic [SUB_W-1:0] MAJ_T0 = SUB_W'(7);
    localparam logic [SUB_W-1:0] MAJ_T1 = SUB_W'(8);
    localparam logic [SUB_W-1:0] MAJ_T2 = SUB_W'(9);

    // Clock cycles per 16x tick, rounded to nearest.
    function automatic int baud_divisor(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// PicoBlaze-side input port of the UART receiver.
// The processor is master: it strobes reads and observes data/status.
interface uart_rx_port_if;

    logic       READ_STROBE;
    logic [7:0] RX_DATA;
    logic       RX_READY;
    logic       OVERRUN;
    logic       FRAMING_ERR;

    modport master (
        output READ_STROBE,
        input  RX_DATA,
        input  RX_READY,
        input  OVERRUN,
        input  FRAMING_ERR
    );

    modport slave (
        input  READ_STROBE,
        output RX_DATA,
        output RX_READY,
        output OVERRUN,
        output FRAMING_ERR
    );

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator shared by the RX and TX paths.
// Counter is held at zero while disabled so a new frame starts phase-aligned.
module uart_baud_tick #(
    parameter int DIVISOR = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver presented to the PicoBlaze as a data/status input port.
// Majority-votes three mid-bit samples; flags are sticky until read.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 115200,
    parameter int DIVISOR = baud_divisor(CLK_HZ, BAUD)
) (
    input  logic           CLK_IN,
    input  logic           RESET_IN,
    input  logic           RX_IN,
    uart_rx_port_if.slave  bus
);

    uart_state_t      state;
    uart_state_t      state_nxt;
    logic             rx_m;
    logic             rx_s;
    logic             rx_d;
    logic             enable;
    logic             tick;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] tick_idx;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             v7;
    logic             v8;
    logic             sample;
    logic             decide;
    logic             frame_ok;
    logic             frame_bad;
    logic [7:0]       data_q;
    logic             ready_q;
    logic             ovr_q;
    logic             ferr_q;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= RX_IN;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign enable = (state == ST_START) ||
                    (state == ST_DATA)  ||
                    (state == ST_STOP);

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clk    (CLK_IN),
        .rst    (RESET_IN),
        .enable (enable),
        .tick   (tick)
    );

    // Ticks are numbered 1..15,0 within a bit so tick 8 is mid-bit.
    assign tick_idx = sub + 1'b1;
    assign sample   = maj3(v7, v8, rx_s);
    assign decide   = tick && (tick_idx == MAJ_T2);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sub <= '0;
            v7  <= 1'b0;
            v8  <= 1'b0;
        end else if (!enable) begin
            sub <= '0;
        end else if (tick) begin
            sub <= tick_idx;
            if (tick_idx == MAJ_T0) v7 <= rx_s;
            if (tick_idx == MAJ_T1) v8 <= rx_s;
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state != ST_DATA) begin
            bit_idx <= '0;
        end else if (decide) begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= {sample, shreg[7:1]};
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_d && !rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (decide) state_nxt = sample ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide && bit_idx == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    if (sample) begin
                        frame_ok  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A read in the same cycle as a completion frees the slot for the new byte.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            data_q  <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (frame_ok) begin
                if (!ready_q || bus.READ_STROBE) begin
                    data_q  <= shreg;
                    ready_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (bus.READ_STROBE) begin
                ready_q <= 1'b0;
                ovr_q   <= 1'b0;
                ferr_q  <= 1'b0;
            end
            if (frame_bad) ferr_q <= 1'b1;
        end
    end

    assign bus.RX_DATA     = data_q;
    assign bus.RX_READY    = ready_q;
    assign bus.OVERRUN     = ovr_q;
    assign bus.FRAMING_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port, run at 4 clocks per tick (64 per bit).
// Serial frames are driven on falling clock edges; outputs sampled there too.
module tb_uart_rx_port;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 1_562_500;
    localparam int BC     = 64;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    int   tests = 0;
    int   fails = 0;

    uart_rx_port_if bus();

    uart_rx_port #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .CLK_IN   (clk),
        .RESET_IN (rst),
        .RX_IN    (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame; spike >= 0 inverts the line for that one cycle.
    task automatic send(input logic [7:0] d, input int bc,
                        input logic stop, input int spike);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int c = 0; c < 10 * bc; c++) begin
            rx = fr[c / bc] ^ (c == spike);
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.RX_READY !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_timeout", cyc < 2000, 1);
    endtask

    task automatic read_port();
        bus.READ_STROBE = 1'b1;
        @(negedge clk);
        bus.READ_STROBE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        rx  = 1'b1;
        bus.READ_STROBE = 1'b0;
        idle(3);
        check("rst_data",  bus.RX_DATA, 8'h00);
        check("rst_ready", bus.RX_READY, 0);
        check("rst_ovr",   bus.OVERRUN, 0);
        check("rst_ferr",  bus.FRAMING_ERR, 0);
        rst = 1'b0;
        idle(5);

        // Edge at N0 -> START at P3; stop tick 9 is tick 153 -> ready at N615.
        fork
            send(8'hA5, BC, 1'b1, -1);
            wait_ready(lat);
        join
        check("a5_latency", lat >= 612 && lat <= 618, 1);
        check("a5_data", bus.RX_DATA, 8'hA5);
        check("a5_ovr",  bus.OVERRUN, 0);
        check("a5_ferr", bus.FRAMING_ERR, 0);
        read_port();
        check("a5_read_ready", bus.RX_READY, 0);
        check("a5_read_hold",  bus.RX_DATA, 8'hA5);

        send(8'h3C, BC, 1'b1, -1);
        send(8'hC3, BC, 1'b1, -1);
        idle(10);
        check("ovr_data",  bus.RX_DATA, 8'h3C);
        check("ovr_ready", bus.RX_READY, 1);
        check("ovr_flag",  bus.OVERRUN, 1);
        read_port();
        check("ovr_clr_ready", bus.RX_READY, 0);
        check("ovr_clr_flag",  bus.OVERRUN, 0);

        send(8'h55, BC, 1'b0, -1);
        idle(100);
        check("fe_flag",  bus.FRAMING_ERR, 1);
        check("fe_ready", bus.RX_READY, 0);
        check("fe_data",  bus.RX_DATA, 8'h3C);
        send(8'h12, BC, 1'b1, -1);
        idle(10);
        check("fe_next_data",  bus.RX_DATA, 8'h12);
        check("fe_next_ready", bus.RX_READY, 1);
        check("fe_sticky",     bus.FRAMING_ERR, 1);
        read_port();
        check("fe_clr_flag",  bus.FRAMING_ERR, 0);
        check("fe_clr_ready", bus.RX_READY, 0);

        rx = 1'b0;
        idle(15);
        rx = 1'b1;
        idle(200);
        check("gl_ready", bus.RX_READY, 0);
        check("gl_ovr",   bus.OVERRUN, 0);
        check("gl_ferr",  bus.FRAMING_ERR, 0);
        send(8'h81, BC, 1'b1, -1);
        idle(10);
        check("gl_next_data",  bus.RX_DATA, 8'h81);
        check("gl_next_ready", bus.RX_READY, 1);
        read_port();

        send(8'hF0, 62, 1'b1, -1);
        idle(10);
        check("fast_data",  bus.RX_DATA, 8'hF0);
        check("fast_ready", bus.RX_READY, 1);
        check("fast_ferr",  bus.FRAMING_ERR, 0);
        read_port();
        send(8'hF0, 66, 1'b1, -1);
        idle(10);
        check("slow_data",  bus.RX_DATA, 8'hF0);
        check("slow_ready", bus.RX_READY, 1);
        check("slow_ferr",  bus.FRAMING_ERR, 0);
        read_port();

        // Spike lands on the tick-8 sample of data bit 3 (a 0 in 8'h96).
        send(8'h96, BC, 1'b1, 4 * BC + 32);
        idle(10);
        check("spike_data",  bus.RX_DATA, 8'h96);
        check("spike_ready", bus.RX_READY, 1);

        fork
            send(8'h5A, BC, 1'b1, -1);
            begin
                idle(4 * BC + 30);
                rst = 1'b1;
                @(negedge clk);
                check("mid_rst_data",  bus.RX_DATA, 8'h00);
                check("mid_rst_ready", bus.RX_READY, 0);
                check("mid_rst_ovr",   bus.OVERRUN, 0);
                check("mid_rst_ferr",  bus.FRAMING_ERR, 0);
            end
        join
        rst = 1'b0;
        idle(20);
        check("post_rst_quiet", bus.RX_READY, 0);
        send(8'h7E, BC, 1'b1, -1);
        idle(10);
        check("post_rst_data",  bus.RX_DATA, 8'h7E);
        check("post_rst_ready", bus.RX_READY, 1);
        check("post_rst_ovr",   bus.OVERRUN, 0);
        check("post_rst_ferr",  bus.FRAMING_ERR, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
